// File: rtl/sprite_blitter_if.sv
// Request, sprite ROM and pixel-write signals of the sprite blitter.
// master = requester/ROM/VGA side, slave = blitter.
interface sprite_blitter_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic              mode;
  logic [7:0]        x0;
  logic [6:0]        y0;
  logic [7:0]        w;
  logic [6:0]        h;
  logic [2:0]        fill_colour;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_data;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              plot;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, x0, y0, w, h, fill_colour, rom_data,
    input  rom_addr, x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, mode, x0, y0, w, h, fill_colour, rom_data,
    output rom_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// Raster-scans a w x h rectangle, one pixel slot per cycle, as a solid fill or a sprite-ROM copy.
// Pixel slot lags issue by one cycle to line up with synchronous ROM data; no backpressure, start only taken in IDLE.
module sprite_blitter #(
  parameter int       SCREEN_W    = 160,
  parameter int       SCREEN_H    = 120,
  parameter int       ADDR_W      = 15,
  parameter int       TRANSP_EN   = 1,
  parameter bit [2:0] TRANSPARENT = 3'b111
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  sprite_blitter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d, x0_q, x0_d, w_q, w_d, x_q, x_d;
  logic [6:0]        j_q, j_d, y0_q, y0_d, h_q, h_d, y_q, y_d;
  logic              mode_q, mode_d;
  logic [2:0]        fill_q, fill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pix_q, pix_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [8:0]        px;
  logic [7:0]        py;
  logic              transparent;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    pix_d   = 1'b0;
    done_d  = 1'b0;
    px      = {1'b0, x0_q} + {1'b0, i_q};
    py      = {1'b0, y0_q} + {1'b0, j_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x0_d   = bus.x0;
          y0_d   = bus.y0;
          w_d    = bus.w;
          h_d    = bus.h;
          mode_d = bus.mode;
          fill_d = bus.fill_colour;
          i_d    = '0;
          j_d    = '0;
          addr_d = '0;
          if (bus.w == 8'd0 || bus.h == 7'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Clipping uses the unwrapped sums; the scan carries on regardless.
        pix_d = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
        x_d   = px[7:0];
        y_d   = py[6:0];
        if (i_q == w_q - 8'd1) begin
          i_d = '0;
          if (j_q == h_q - 7'd1) begin
            state_d = FLUSH;
          end else begin
            j_d    = j_q + 7'd1;
            addr_d = addr_q + 1'b1;
          end
        end else begin
          i_d    = i_q + 8'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FLUSH);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pix_q   <= pix_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // rom_data belongs to the slot being presented, so colour/transparency stay combinational on it.
  assign transparent  = (TRANSP_EN != 0) && mode_q && (bus.rom_data == TRANSPARENT);
  assign bus.colour   = mode_q ? bus.rom_data : fill_q;
  assign bus.plot     = pix_q && !transparent;
  assign bus.rom_addr = addr_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a synchronous ROM model and per-request capture of the pixel port.
module tb_sprite_blitter;
  logic CLOCK_50;
  logic reset;
  int   checks;
  int   failures;

  sprite_blitter_if #(.ADDR_W(15)) bus ();

  sprite_blitter #(
    .SCREEN_W(160), .SCREEN_H(120), .ADDR_W(15), .TRANSP_EN(1), .TRANSPARENT(3'b111)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic [2:0] rom_mem [0:63];
  always @(posedge CLOCK_50) bus.rom_data <= rom_mem[bus.rom_addr[5:0]];

  int obs_x[$], obs_y[$], obs_c[$];
  int exp_x[$], exp_y[$], exp_c[$];
  int done_n, done_cnt, first_n, addr_ok;
  bit busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Issues one request and watches the port until 4 cycles past the first done.
  // Sample n is taken n cycles after the edge that sampled start.
  task automatic run_req(input bit m, input int x0, input int y0, input int w, input int h,
                         input int fc, input bit poke);
    int n;
    int wh;
    wh = w * h;
    obs_x.delete(); obs_y.delete(); obs_c.delete();
    done_n = 0; done_cnt = 0; first_n = 0; addr_ok = 0; busy_seen = 0;
    @(negedge CLOCK_50);
    bus.start = 1'b1; bus.mode = m; bus.x0 = 8'(x0); bus.y0 = 7'(y0);
    bus.w = 8'(w); bus.h = 7'(h); bus.fill_colour = 3'(fc);
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    bus.x0 = 8'd0; bus.y0 = 7'd0; bus.w = 8'd1; bus.h = 7'd1; bus.fill_colour = 3'd0;
    n = 1;
    while (n < 400) begin
      if (bus.plot) begin
        obs_x.push_back(int'(bus.x));
        obs_y.push_back(int'(bus.y));
        obs_c.push_back(int'(bus.colour));
        if (first_n == 0) first_n = n;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (n <= wh && int'(bus.rom_addr) == n - 1) addr_ok++;
      if (poke && n == 3) bus.start = 1'b1;
      if (poke && n == 4) bus.start = 1'b0;
      if (poke && done_n == n) bus.start = 1'b1;
      if (poke && done_n != 0 && n == done_n + 1) bus.start = 1'b0;
      if (done_n != 0 && n >= done_n + 4) break;
      @(negedge CLOCK_50);
      n++;
    end
  endtask

  task automatic check_pixels(input string tag);
    check({tag, "_count"}, obs_x.size(), exp_x.size());
    for (int k = 0; k < exp_x.size() && k < obs_x.size(); k++) begin
      check($sformatf("%s_x%0d", tag, k), obs_x[k], exp_x[k]);
      check($sformatf("%s_y%0d", tag, k), obs_y[k], exp_y[k]);
      check($sformatf("%s_c%0d", tag, k), obs_c[k], exp_c[k]);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int a = 0; a < 64; a++) rom_mem[a] = 3'(a % 7);
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.w = '0; bus.h = '0; bus.fill_colour = '0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_plot", bus.plot, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_colour", bus.colour, 0);
    check("rst_addr", bus.rom_addr, 0);
    reset = 1'b0;

    // Solid fill 3x2 at (10,20).
    run_req(1'b0, 10, 20, 3, 2, 2, 1'b0);
    exp_x = '{10, 11, 12, 10, 11, 12};
    exp_y = '{20, 20, 20, 21, 21, 21};
    exp_c = '{2, 2, 2, 2, 2, 2};
    check_pixels("fill");
    check("fill_first", first_n, 2);
    check("fill_done", done_n, 8);
    check("fill_busy", busy_seen, 1);

    // Sprite 4x4 at (30,40), ROM = addr mod 7, nothing transparent.
    run_req(1'b1, 30, 40, 4, 4, 5, 1'b0);
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    for (int k = 0; k < 16; k++) begin
      exp_x.push_back(30 + k % 4);
      exp_y.push_back(40 + k / 4);
      exp_c.push_back(k % 7);
    end
    check_pixels("spr");
    check("spr_addr_seq", addr_ok, 16);
    check("spr_done", done_n, 18);

    // Sprite with column 3 transparent, plus starts pulsed in RUN and DONE.
    for (int a = 0; a < 64; a++) rom_mem[a] = (a % 4 == 3) ? 3'd7 : 3'(a % 7);
    run_req(1'b1, 30, 40, 4, 4, 5, 1'b1);
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    for (int k = 0; k < 16; k++) begin
      if (k % 4 != 3) begin
        exp_x.push_back(30 + k % 4);
        exp_y.push_back(40 + k / 4);
        exp_c.push_back(k % 7);
      end
    end
    check_pixels("transp");
    check("ignored_start_done_cnt", done_cnt, 1);
    check("transp_done", done_n, 18);

    // Clipping at the bottom-right corner.
    run_req(1'b0, 158, 119, 4, 2, 1, 1'b0);
    exp_x = '{158, 159};
    exp_y = '{119, 119};
    exp_c = '{1, 1};
    check_pixels("clip");
    check("clip_done", done_n, 10);

    // Degenerate width.
    run_req(1'b0, 5, 5, 0, 5, 4, 1'b0);
    check("degen_plots", obs_x.size(), 0);
    check("degen_done", done_n, 1);
    check("degen_busy", busy_seen, 0);
    check("degen_done_cnt", done_cnt, 1);

    // Reset in the 5th RUN cycle of a 16x16 fill.
    @(negedge CLOCK_50);
    bus.start = 1'b1; bus.mode = 1'b0; bus.x0 = 8'd5; bus.y0 = 7'd6;
    bus.w = 8'd16; bus.h = 7'd16; bus.fill_colour = 3'd5;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_x", bus.x, 8);
    reset = 1'b1;
    #1;
    check("mid_rst_plot", bus.plot, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_x", bus.x, 0);
    check("mid_rst_y", bus.y, 0);
    check("mid_rst_colour", bus.colour, 0);
    check("mid_rst_addr", bus.rom_addr, 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    run_req(1'b0, 1, 2, 2, 2, 6, 1'b0);
    exp_x = '{1, 2, 1, 2};
    exp_y = '{2, 2, 3, 3};
    exp_c = '{6, 6, 6, 6};
    check_pixels("rereq");
    check("rereq_done", done_n, 6);
    check("rereq_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
